// File: rtl/seg_scan_driver.sv
// Multiplexed 7-segment driver: sequential double-dabble binary-to-BCD plus a digit scanner.
// Optional macro SEG_LZ_BLANK_EN blanks leading zero digits (digit 0 is always shown).
module seg_scan_driver #(
   parameter int unsigned NUM_DIGITS = 4,
   parameter int unsigned VAL_W      = 10,
   parameter int unsigned SCAN_DIV   = 1000
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [VAL_W-1:0]      value_i,
   input  logic                  load_i,
   output logic                  busy_o,
   output logic                  ovf_o,
   output logic [NUM_DIGITS-1:0] digit_o,
   output logic [6:0]            seg_data_o
);

   localparam int unsigned BCD_W = 4 * NUM_DIGITS;
   localparam int unsigned IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
   localparam int unsigned PRE_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam int unsigned CNT_W = $clog2(VAL_W + 1);

   function automatic int unsigned max_disp();
      int unsigned m;
      m = 1;
      for (int i = 0; i < int'(NUM_DIGITS); i++) m = m * 10;
      return m - 1;
   endfunction

   localparam int unsigned MAX_VAL = max_disp();

   localparam logic [1:0] IDLE   = 2'd0;
   localparam logic [1:0] CONV   = 2'd1;
   localparam logic [1:0] COMMIT = 2'd2;

   logic [1:0]            state_q;
   logic [VAL_W-1:0]      sh_q;
   logic [BCD_W-1:0]      bcd_q, bcd_adj, bcd_shift;
   logic [CNT_W-1:0]      cnt_q;
   logic                  ovf_flag_q;
   logic [BCD_W-1:0]      disp_q;
   logic                  ovf_q;
   logic                  shown_valid_q;
   logic [PRE_W-1:0]      presc_q, presc_d;
   logic [IDX_W-1:0]      idx_q, idx_d;
   logic [NUM_DIGITS-1:0] digit_q;
   logic [6:0]            seg_q, seg_d;
   logic                  tick;
   logic [3:0]            cur_nib;
   logic                  upper_zero;

   assign busy_o     = (state_q != IDLE);
   assign ovf_o      = ovf_q;
   assign digit_o    = digit_q;
   assign seg_data_o = seg_q;

   always_comb begin
      bcd_adj = '0;
      for (int i = 0; i < int'(NUM_DIGITS); i++) begin
         bcd_adj[4*i +: 4] = (bcd_q[4*i +: 4] >= 4'd5) ? bcd_q[4*i +: 4] + 4'd3 : bcd_q[4*i +: 4];
      end
      // Bit shifted out of the top nibble is dropped; only matters on overflow.
      bcd_shift = (bcd_adj << 1) | BCD_W'(sh_q[VAL_W-1]);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= IDLE;
         sh_q          <= '0;
         bcd_q         <= '0;
         cnt_q         <= '0;
         ovf_flag_q    <= 1'b0;
         disp_q        <= '0;
         ovf_q         <= 1'b0;
         shown_valid_q <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (load_i) begin
                  sh_q       <= value_i;
                  bcd_q      <= '0;
                  cnt_q      <= '0;
                  ovf_flag_q <= (32'(value_i) > MAX_VAL);
                  state_q    <= CONV;
               end
            end
            CONV: begin
               bcd_q <= bcd_shift;
               sh_q  <= sh_q << 1;
               cnt_q <= cnt_q + 1'b1;
               if (cnt_q == CNT_W'(VAL_W - 1)) state_q <= COMMIT;
            end
            COMMIT: begin
               disp_q        <= bcd_q;
               ovf_q         <= ovf_flag_q;
               shown_valid_q <= 1'b1;
               state_q       <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   always_comb begin
      tick    = (presc_q == PRE_W'(SCAN_DIV - 1));
      presc_d = tick ? '0 : presc_q + 1'b1;
      idx_d   = idx_q;
      if (tick) idx_d = (idx_q == '0) ? IDX_W'(NUM_DIGITS - 1) : idx_q - 1'b1;
   end

   function automatic logic [6:0] dec7(input logic [3:0] d);
      case (d)
         4'd0:    return 7'h3F;
         4'd1:    return 7'h06;
         4'd2:    return 7'h5B;
         4'd3:    return 7'h4F;
         4'd4:    return 7'h66;
         4'd5:    return 7'h6D;
         4'd6:    return 7'h7D;
         4'd7:    return 7'h07;
         4'd8:    return 7'h7F;
         4'd9:    return 7'h6F;
         default: return 7'h00;
      endcase
   endfunction

   // Decode uses the next index so enable and data change on the same edge.
   always_comb begin
      cur_nib    = 4'd0;
      upper_zero = 1'b1;
      for (int i = 0; i < int'(NUM_DIGITS); i++) begin
         if (IDX_W'(i) == idx_d) cur_nib = disp_q[4*i +: 4];
         if (IDX_W'(i) >= idx_d && disp_q[4*i +: 4] != 4'd0) upper_zero = 1'b0;
      end
      if (!shown_valid_q) begin
         seg_d = 7'h00;
      end else if (ovf_q) begin
         seg_d = 7'h40;
      end else begin
`ifdef SEG_LZ_BLANK_EN
         seg_d = (idx_d != '0 && upper_zero) ? 7'h00 : dec7(cur_nib);
`else
         seg_d = dec7(cur_nib);
`endif
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         presc_q <= '0;
         idx_q   <= IDX_W'(NUM_DIGITS - 1);
         digit_q <= NUM_DIGITS'(1) << (NUM_DIGITS - 1);
         seg_q   <= 7'h00;
      end else begin
         presc_q <= presc_d;
         idx_q   <= idx_d;
         digit_q <= NUM_DIGITS'(1) << idx_d;
         seg_q   <= seg_d;
      end
   end

endmodule

// File: doc/seg_scan_driver.md
# seg_scan_driver

Parametrised multiplexed 7-segment display driver: converts a binary value to BCD with a sequential double-dabble engine, then scans it over `NUM_DIGITS` common-anode/cathode digits at a programmable refresh rate. It sits between the datapath counters (row/frame counters) and the board display pins. It generalises the fixed 4-digit, 10-bit driver with these additions:

- arbitrary width and digit count;
- atomic display update with a load handshake;
- overflow indication;
- a scan prescaler;
- optional leading-zero blanking.

## Interface
- `NUM_DIGITS`, default 4: number of display digits, 1–8.
- `VAL_W`, default 10: width of the binary input, 1–27.
- `SCAN_DIV`, default 1000: clocks per digit dwell, ≥1.
- `clk`, input, 1: clock.
- `rst_n`, input, 1: reset; asynchronous, active-low.
- `value_i`, input, VAL_W: unsigned binary value to display.
- `load_i`, input, 1: request to capture `value_i`; single-cycle pulse or level.
- `busy_o`, output, 1: conversion in progress; `load_i` is ignored while high.
- `ovf_o`, output, 1: the last committed value exceeded 10^NUM_DIGITS−1.
- `digit_o`, output, NUM_DIGITS: one-hot digit enable, active-high; bit i selects digit i, where i=0 is the least significant digit.
- `seg_data_o`, output, 7: segments {g,f,e,d,c,b,a}, active-high (1 = lit).

## Operation
- FSM states: IDLE, CONV, COMMIT.
  - IDLE → CONV when `load_i`=1. At that edge: capture `value_i` into the shift register, clear the BCD accumulator, and latch `ovf_flag = (value_i > 10^NUM_DIGITS−1)`.
  - CONV: run exactly VAL_W double-dabble iterations, one per clock. Each iteration adds 3 to every BCD nibble ≥5, then shifts left by 1. The BCD accumulator is 4·NUM_DIGITS bits; the bit shifted out of the top is discarded.
  - CONV → COMMIT after the VAL_W-th iteration.
  - COMMIT: copy the accumulator into the display registers, copy `ovf_flag` to `ovf_o`, set `shown_valid`=1. COMMIT → IDLE.
- `busy_o` = 1 in CONV and COMMIT.
- `load_i` in CONV or COMMIT is dropped, not queued.
- Scan:
  - The prescaler counts 0..SCAN_DIV−1; the tick is at terminal count.
  - The digit index counts down from NUM_DIGITS−1 to 0, then wraps to NUM_DIGITS−1.
  - `digit_o` = 1 << index.
- Segment decode is registered from the current index and the display registers:
  - Digits 0–9: 3F, 06, 5B, 4F, 66, 6D, 7D, 07, 7F, 6F (hex).
  - Blank: 00.
  - Dash: 40.
- Decode priority:
  - `shown_valid`=0 → blank.
  - `ovf_o`=1 → dash on every digit.
  - Otherwise → BCD digit, subject to the blanking configuration.
- The display registers change only in COMMIT, so the scan never shows a partially converted value.

## Timing
- Reset values:
  - FSM = IDLE, `busy_o`=0, `ovf_o`=0, `shown_valid`=0.
  - Prescaler = 0, index = NUM_DIGITS−1.
  - `digit_o` = 1 << (NUM_DIGITS−1), `seg_data_o` = 7'h00.
- Conversion latency:
  - `load_i` is sampled at edge 0.
  - `busy_o` is high from edge 0 through edge VAL_W+1.
  - Display registers and `ovf_o` update at edge VAL_W+1.
  - `seg_data_o` reflects the new value at edge VAL_W+2.
  - A new load is accepted at edge VAL_W+2 at the earliest.
- On a scan tick, `digit_o` and `seg_data_o` update on the same edge, so the enable and the data are always aligned.
- Between ticks, `seg_data_o` is re-evaluated every clock for the current digit.
- SCAN_DIV=1: the digit advances every clock.
- NUM_DIGITS=1: `digit_o` is constantly 1.
- Reset asserted mid-conversion: the conversion is aborted, all state returns to reset values, and the display is blank until the next completed load.

## Configuration
- `SEG_LZ_BLANK_EN` defined:
  - Every digit above the most significant nonzero digit displays blank (00).
  - Digit 0 is never blanked, so a value of 0 shows "0" only.
  - Overflow dashes are not blanked.
- `SEG_LZ_BLANK_EN` undefined: every digit is shown, including leading zeros (3F).

## Test plan
- Reset, defaults, no load → `digit_o` cycles 1000→0100→0010→0001→1000 every 1000 clocks, `seg_data_o`=00 throughout, `busy_o`=0.
- Load 987 (VAL_W=10, NUM_DIGITS=4, SCAN_DIV=3) → `busy_o` high for 11 edges. Then digits 3..0 = 3F, 6F, 7F, 07 without the macro; 00, 6F, 7F, 07 with it.
- Load 0 → digit 0 = 3F. Other digits are 3F without the macro and 00 with it.
- NUM_DIGITS=2, load 100 → `ovf_o`=1 and both digits show 40. Then load 42 → `ovf_o`=0, digits show 66, 5B.
- Load 5, then pulse `load_i` with 9 at edge 3 → the 9 is ignored and the display shows 6D. A load of 9 at edge 12 is accepted.
- Load 987, then assert `rst_n`=0 at edge 5 → all outputs return to reset values and the display stays blank after release.
